mem_access_ctrl: RTL
====================

# mem_access_ctrl

Multicycle sequencer for data-memory loads and stores in the CPU datapath. Accepts one load or store request from the main control unit, drives the memory port for a fixed read latency, captures the read word into its MDR, and issues the size command consumed by the load-size unit. Sub-word stores are done as a read-modify-write. Signals completion, or a misalignment error, to the control unit.

## Interface
Parameters:
- MEM_LATENCY, default 1: cycles from address presentation to valid `mem_rdata`. Range 1–15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  op[2] = 1 store, 0 load; op[1:0] = size: 10 word, 01 halfword, 00 byte, 11 illegal.
- addr  in  32  byte address; latched on accepted start.
- wdata  in  32  store data; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on misaligned or illegal op.
- mem_addr  out  32  word address to memory: latched addr with [1:0] forced to 00.
- mem_wr  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- mdr_out  out  32  MDR contents.
- ls_cmd  out  2  size command to the load-size unit; equals latched op[1:0] on loads; 10 otherwise.

## Operation
- States: IDLE, READ, CAPTURE, WRITE, DONE, ERR.
- IDLE: on start=1, latch op, addr, wdata.
  - op[1:0]=11, word access with addr[1:0]≠00, or halfword access with addr[0]≠0 → ERR.
  - SW → WRITE.
  - Any other op → READ.
  - start while busy is ignored, not queued.
- READ: mem_addr valid, mem_wr=0. A 4-bit counter starts at 0 and increments each cycle. When counter = MEM_LATENCY−1 → CAPTURE.
- CAPTURE: MDR ← mem_rdata at the end of this cycle. Loads → DONE; SH/SB → WRITE.
- WRITE: mem_wr=1 for exactly one cycle. Write data by op:
  - SW: latched wdata.
  - SH: {mdr[31:16], wdata[15:0]}.
  - SB: {mdr[31:8], wdata[7:0]}.
  - Sub-word lanes are always the low lanes, matching the load-size unit's extraction.
  - Next state → DONE.
- DONE: done=1 → IDLE. ERR: done=1, err=1 → IDLE. No memory write occurs on any error path.
- MDR holds its value between operations; it changes only in CAPTURE.

## Timing
- Reset values (state after the first clock edge with reset=0): state IDLE; busy, done, err, mem_wr = 0; mem_addr, mem_wdata, mdr_out = 0; ls_cmd = 10; counter = 0.
- Reset mid-operation aborts to IDLE on that edge, with mem_wr=0 immediately after the edge. No done pulse is issued.
- Latency counts edges after the edge that samples start, with T = MEM_LATENCY:
  - Load: done high during cycle T+2.
  - SW: done in cycle 2.
  - SH/SB: done in cycle T+3.
  - Error: done/err in cycle 1.
- busy is high from the cycle after start through the DONE/ERR cycle. start may be reasserted in the cycle after done.
- mdr_out and ls_cmd are stable from the DONE cycle until the next CAPTURE or next accepted start, so the register file may write back in the DONE cycle.
- All outputs are registered or decoded from state only. No combinational path from start or mem_rdata to any output.

## Structure
- Package `mem_ctrl_pkg`:
  - size encodings SZ_WORD=2'b10, SZ_HALF=2'b01, SZ_BYTE=2'b00.
  - state encoding constants.
  - op field positions.
- Sub-module `store_merge`, purely combinational: inputs size, mdr, wdata; output merged word. It is instantiated once and is reusable by the store-size path.

## Test plan
- Reset: hold reset=0 for 2 cycles mid-READ → IDLE, busy=0, mem_wr=0, no done pulse.
- LW, addr=0x0000_0010, mem_rdata=0xDEAD_BEEF, MEM_LATENCY=1 → mem_addr=0x10, done in cycle 3, mdr_out=0xDEAD_BEEF, ls_cmd=10.
- SB, addr=0x21, wdata=0x0000_00AB, memory word 0x1122_3344 → one write of 0x1122_33AB to 0x20, done in cycle 4.
- SH, addr=0x08, wdata=0xFFFF_5566, memory 0xAAAA_BBBB, MEM_LATENCY=3 → write 0xAAAA_5566, done in cycle 6.
- LW, addr=0x0000_0006 → err=done=1 in cycle 1, mem_wr never asserted. op=3'b011 → same response.
- Back-to-back: start held high during a busy SW → exactly one operation until done. A new start the cycle after done is accepted.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Brief    : Shared encodings for the data-memory access sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int OP_STORE_BIT = 2;
    localparam int OP_SIZE_MSB  = 1;
    localparam int OP_SIZE_LSB  = 0;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READ    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_READ    = ST_READ,
        S_CAPTURE = ST_CAPTURE,
        S_WRITE   = ST_WRITE,
        S_DONE    = ST_DONE,
        S_ERR     = ST_ERR
    } state_t;

    // Illegal size, or an address that does not sit on the access boundary.
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_ILL:  bad = 1'b1;
            SZ_WORD: bad = (lo != 2'b00);
            SZ_HALF: bad = lo[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_merge.sv
`default_nettype none
// ============================================================================
// Module   : store_merge
// Brief    : Merges sub-word store data into the low lanes of a memory word.
// Revision : 1.0 - initial release
// ============================================================================
module store_merge
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] mdr,
    input  logic [31:0] wdata,
    output logic [31:0] merged
);

    always_comb begin
        merged = wdata;
        case (size)
            SZ_HALF: merged = {mdr[31:16], wdata[15:0]};
            SZ_BYTE: merged = {mdr[31:8],  wdata[7:0]};
            default: merged = wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Multicycle load/store sequencer with read-modify-write sub-word stores.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mdr_out,
    output logic [1:0]  ls_cmd
);

    localparam logic [3:0] C_LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [29:0] r_waddr;
    logic [31:0] r_wdata;
    logic [31:0] r_mdr;
    logic [3:0]  r_cnt;
    logic [1:0]  r_ls_cmd;
    logic [31:0] w_merged;
    logic        w_accept;
    logic        w_bad;
    logic        w_store;
    logic [1:0]  w_size;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_store  = op[OP_STORE_BIT];
    assign w_size   = op[OP_SIZE_MSB:OP_SIZE_LSB];
    assign w_bad    = access_bad(w_size, addr[1:0]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_bad)
                        w_next = S_ERR;
                    else if (w_store && (w_size == SZ_WORD))
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ:    if (r_cnt == C_LAST_CNT) w_next = S_CAPTURE;
            S_CAPTURE: w_next = r_op[OP_STORE_BIT] ? S_WRITE : S_DONE;
            S_WRITE:   w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            S_ERR:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op     <= 3'b000;
            r_waddr  <= 30'd0;
            r_wdata  <= 32'd0;
            r_mdr    <= 32'd0;
            r_cnt    <= 4'd0;
            r_ls_cmd <= SZ_WORD;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op     <= op;
                r_waddr  <= addr[31:2];
                r_wdata  <= wdata;
                r_ls_cmd <= w_store ? SZ_WORD : w_size;
            end
            // Counter only runs while waiting on the memory read latency.
            if (r_state == S_READ)
                r_cnt <= r_cnt + 4'd1;
            else
                r_cnt <= 4'd0;
            if (r_state == S_CAPTURE)
                r_mdr <= mem_rdata;
        end
    end

    store_merge u_store_merge (
        .size   (r_op[OP_SIZE_MSB:OP_SIZE_LSB]),
        .mdr    (r_mdr),
        .wdata  (r_wdata),
        .merged (w_merged)
    );

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE) || (r_state == S_ERR);
    assign err       = (r_state == S_ERR);
    assign mem_wr    = (r_state == S_WRITE);
    assign mem_addr  = {r_waddr, 2'b00};
    assign mem_wdata = w_merged;
    assign mdr_out   = r_mdr;
    assign ls_cmd    = r_ls_cmd;

endmodule
`default_nettype wire
